mem_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-fetch (IF) and data (MEM) stages of the 5-stage pipeline.
- Produces the `mem_stall` signal consumed by `control_unit`. While it is high, the whole pipeline freezes until every pending request of the current cycle has been served.
- When both stages request in the same cycle, the data access is served first, then the fetch.
- A bus watchdog bounds every transaction.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single external memory port between the IF and MEM pipeline stages.
// A data access goes out before a fetch, and every bus transaction is bounded by a watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        mem_stall,
    output logic        bus_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_INSTR = 2'd2;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        dm_done;
    logic        if_done;
    logic [15:0] wd_cnt;
    logic        dm_pending;
    logic        if_pending;
    logic        busy;
    logic        wd_fire;
    logic        complete;
    logic        load_dm;
    logic        load_if;
    logic        release_bus;
    logic [31:0] read_word;

    assign dm_pending = dm_req & ~dm_done;
    assign if_pending = if_req & ~if_done;
    assign mem_stall  = dm_pending | if_pending;

    // A watchdog expiry is treated exactly like an ack that returns zero.
    assign busy      = (state == S_DATA) || (state == S_INSTR);
    assign wd_fire   = busy & ~bus_ack & (wd_cnt == WD_LAST);
    assign complete  = busy & (bus_ack | wd_fire);
    assign read_word = bus_ack ? bus_rdata : 32'h0;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dm_pending) begin
                    state_next = S_DATA;
                end else if (if_pending) begin
                    state_next = S_INSTR;
                end
            end
            S_DATA: begin
                if (complete) begin
                    state_next = if_pending ? S_INSTR : S_IDLE;
                end
            end
            S_INSTR: begin
                if (complete) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign load_dm     = (state == S_IDLE) & (state_next == S_DATA);
    assign load_if     = (state != S_INSTR) & (state_next == S_INSTR);
    assign release_bus = complete & (state_next == S_IDLE);

    // Every busy state exits on completion, so a state change is also a fresh watchdog start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            wd_cnt <= 16'h0;
        end else begin
            state <= state_next;
            if ((state_next != state) || !busy) begin
                wd_cnt <= 16'h0;
            end else if (!bus_ack) begin
                wd_cnt <= wd_cnt + 16'h1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
        end else if (load_dm) begin
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_be    <= dm_be;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
        end else if (load_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_be    <= 4'hF;
            bus_addr  <= if_addr;
            bus_wdata <= 32'h0;
        end else if (release_bus) begin
            bus_req   <= 1'b0;
        end
    end

    // Clearing when the pipeline advances wins over marking a request served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_done <= 1'b0;
            if_done <= 1'b0;
        end else if (!mem_stall) begin
            dm_done <= 1'b0;
            if_done <= 1'b0;
        end else begin
            if (complete && (state == S_DATA)) begin
                dm_done <= 1'b1;
            end
            if (complete && (state == S_INSTR)) begin
                if_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_rdata    <= 32'h0;
            if_rdata    <= 32'h0;
            bus_timeout <= 1'b0;
        end else begin
            bus_timeout <= wd_fire;
            if (complete && (state == S_DATA) && !dm_we) begin
                dm_rdata <= read_word;
            end
            if (complete && (state == S_INSTR)) begin
                if_rdata <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each scenario drives the pipeline and memory sides
// cycle by cycle and compares against hand-computed values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        mem_stall;
    logic        bus_timeout;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_stall(mem_stall), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_bus_req: got %h want 0", bus_req); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_bus_we: got %h want 0", bus_we); end
        total++; if (bus_be !== 4'h0) begin bad++; $display("[TB] FAIL rst_bus_be: got %h want 0", bus_be); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_bus_addr: got %h want 0", bus_addr); end
        total++; if (bus_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_bus_wdata: got %h want 0", bus_wdata); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_if_rdata: got %h want 0", if_rdata); end
        total++; if (dm_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_dm_rdata: got %h want 0", dm_rdata); end
        total++; if (bus_timeout !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeout: got %h want 0", bus_timeout); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_idle: got %h want 0", mem_stall); end
        if_req = 1'b1;
        #1;
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL rst_stall_eq: got %h want 1", mem_stall); end
        if_req = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_release_bus_req: got %h want 0", bus_req); end
    endtask

    task automatic test_fetch_only();
        tick();
        if_req = 1'b1; if_addr = 32'h8000_0000;
        #1;
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL fetch_stall_c0: got %h want 1", mem_stall); end
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL fetch_bus_req_c1: got %h want 1", bus_req); end
        total++; if (bus_addr !== 32'h8000_0000) begin bad++; $display("[TB] FAIL fetch_bus_addr_c1: got %h want 80000000", bus_addr); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("[TB] FAIL fetch_bus_we_c1: got %h want 0", bus_we); end
        total++; if (bus_be !== 4'hF) begin bad++; $display("[TB] FAIL fetch_bus_be_c1: got %h want f", bus_be); end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL fetch_stall_c1: got %h want 1", mem_stall); end
        bus_ack = 1'b1; bus_rdata = 32'h3C1D_0001;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL fetch_stall_c2: got %h want 0", mem_stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL fetch_bus_req_c2: got %h want 0", bus_req); end
        total++; if (if_rdata !== 32'h3C1D_0001) begin bad++; $display("[TB] FAIL fetch_if_rdata: got %h want 3c1d0001", if_rdata); end
        if_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b1100; dm_addr = 32'h0000_1000; dm_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h8000_0004;
        #1;
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL sim_stall_c0: got %h want 1", mem_stall); end
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL sim_bus_req_c1: got %h want 1", bus_req); end
        total++; if (bus_addr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL sim_bus_addr_c1: got %h want 00001000", bus_addr); end
        total++; if (bus_be !== 4'b1100) begin bad++; $display("[TB] FAIL sim_bus_be_c1: got %h want c", bus_be); end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL sim_stall_c1: got %h want 1", mem_stall); end
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_rdata = 32'h0000_0000;
        total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL sim_bus_req_c2: got %h want 1", bus_req); end
        total++; if (bus_addr !== 32'h8000_0004) begin bad++; $display("[TB] FAIL sim_bus_addr_c2: got %h want 80000004", bus_addr); end
        total++; if (bus_be !== 4'hF) begin bad++; $display("[TB] FAIL sim_bus_be_c2: got %h want f", bus_be); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("[TB] FAIL sim_bus_we_c2: got %h want 0", bus_we); end
        total++; if (dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL sim_dm_rdata: got %h want deadbeef", dm_rdata); end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL sim_stall_c2: got %h want 1", mem_stall); end
        tick();
        bus_ack = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL sim_bus_req_c3: got %h want 0", bus_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL sim_stall_c3: got %h want 0", mem_stall); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("[TB] FAIL sim_if_rdata: got %h want 0", if_rdata); end
        dm_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_store();
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h0000_2000; dm_wdata = 32'h1234_5678;
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL st_bus_req: got %h want 1", bus_req); end
        total++; if (bus_we !== 1'b1) begin bad++; $display("[TB] FAIL st_bus_we: got %h want 1", bus_we); end
        total++; if (bus_be !== 4'b0011) begin bad++; $display("[TB] FAIL st_bus_be: got %h want 3", bus_be); end
        total++; if (bus_addr !== 32'h0000_2000) begin bad++; $display("[TB] FAIL st_bus_addr: got %h want 00002000", bus_addr); end
        total++; if (bus_wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL st_bus_wdata: got %h want 12345678", bus_wdata); end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if (dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL st_dm_rdata_hold: got %h want deadbeef", dm_rdata); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL st_stall_c2: got %h want 0", mem_stall); end
        dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_slow_memory();
        int stall_cycles = 0;
        int timeouts = 0;
        tick();
        if_req = 1'b1; if_addr = 32'h8000_0008;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (mem_stall === 1'b1) stall_cycles++;
            if (bus_timeout === 1'b1) timeouts++;
            if (c == 3) begin
                bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
            end
            tick();
            if (c < 3) begin
                total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL slow_bus_req_hold c%0d: got %h want 1", c + 1, bus_req); end
                total++; if (bus_addr !== 32'h8000_0008) begin bad++; $display("[TB] FAIL slow_bus_addr_hold c%0d: got %h want 80000008", c + 1, bus_addr); end
            end
        end
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        if (bus_timeout === 1'b1) timeouts++;
        total++; if (stall_cycles != 4) begin bad++; $display("[TB] FAIL slow_stall_cycles: got %0d want 4", stall_cycles); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL slow_stall_c4: got %h want 0", mem_stall); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL slow_no_reissue: got %h want 0", bus_req); end
        total++; if (if_rdata !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL slow_if_rdata: got %h want 0badf00d", if_rdata); end
        total++; if (timeouts != 0) begin bad++; $display("[TB] FAIL slow_timeouts: got %0d want 0", timeouts); end
        if_req = 1'b0;
    endtask

    task automatic test_ack_at_limit();
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_3000;
        repeat (4) tick();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        #1;
        total++; if (dm_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL limit_dm_rdata: got %h want cafef00d", dm_rdata); end
        total++; if (bus_timeout !== 1'b0) begin bad++; $display("[TB] FAIL limit_timeout: got %h want 0", bus_timeout); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL limit_stall: got %h want 0", mem_stall); end
        dm_req = 1'b0;
        tick();
        total++; if (bus_timeout !== 1'b0) begin bad++; $display("[TB] FAIL limit_timeout_late: got %h want 0", bus_timeout); end
    endtask

    task automatic test_watchdog();
        int pulses = 0;
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_4000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus_timeout === 1'b1) pulses++;
            total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL wd_bus_req c%0d: got %h want 1", c, bus_req); end
            total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL wd_stall c%0d: got %h want 1", c, mem_stall); end
        end
        tick();
        if (bus_timeout === 1'b1) pulses++;
        total++; if (bus_timeout !== 1'b1) begin bad++; $display("[TB] FAIL wd_timeout_c5: got %h want 1", bus_timeout); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL wd_bus_req_c5: got %h want 0", bus_req); end
        total++; if (dm_rdata !== 32'h0) begin bad++; $display("[TB] FAIL wd_dm_rdata: got %h want 0", dm_rdata); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL wd_stall_c5: got %h want 0", mem_stall); end
        dm_req = 1'b0;
        tick();
        if (bus_timeout === 1'b1) pulses++;
        total++; if (pulses != 1) begin bad++; $display("[TB] FAIL wd_pulse_count: got %0d want 1", pulses); end
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        total++; if (dm_rdata !== 32'h0) begin bad++; $display("[TB] FAIL idle_ack_dm_rdata: got %h want 0", dm_rdata); end
        total++; if (if_rdata !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL idle_ack_if_rdata: got %h want 0badf00d", if_rdata); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_ack_bus_req: got %h want 0", bus_req); end
    endtask

    task automatic test_reset_mid_transaction();
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_5000;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        total++; if (dm_rdata !== 32'h55AA_55AA) begin bad++; $display("[TB] FAIL mid_pre_dm_rdata: got %h want 55aa55aa", dm_rdata); end
        dm_req = 1'b0;
        tick();
        dm_req = 1'b1; dm_addr = 32'h0000_6000;
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_bus_req_busy: got %h want 1", bus_req); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_bus_req_async: got %h want 0", bus_req); end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL mid_stall_in_reset: got %h want 1", mem_stall); end
        dm_req = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        total++; if (dm_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mid_dm_rdata: got %h want 0", dm_rdata); end
        total++; if (if_rdata !== 32'h0) begin bad++; $display("[TB] FAIL mid_if_rdata: got %h want 0", if_rdata); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("[TB] FAIL mid_bus_addr: got %h want 0", bus_addr); end
        tick();
        total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_idle_after: got %h want 0", bus_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL mid_stall_after: got %h want 0", mem_stall); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: got expired want finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_slow_memory();
        test_ack_at_limit();
        test_watchdog();
        test_reset_mid_transaction();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
